// File: rtl/oam_dma_ctrl_if.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl_if
// Bundles the shared CPU bus signals that the sprite DMA block snoops and
// the bus-master signals it drives in place of the CPU.
//
// Signals:
//   i_bus_addr   [15:0] CPU bus address (snooped)
//   i_bus_wn            CPU write-not (0 = write)
//   i_bus_wdata  [7:0]  CPU write data
//   i_bus_rdata  [7:0]  read data for o_dma_addr (combinational)
//   o_dma_active        bus-mux select, 1 = DMA owns the bus
//   o_dma_addr   [15:0] DMA bus address
//   o_dma_wn            DMA write-not (0 = write)
//   o_dma_wdata  [7:0]  DMA write data
//   o_cpu_rdy           0 = CPU must stall
//   o_done              one-cycle pulse after the last write
//
// Modports:
//   master - the DMA initiator (oam_dma_ctrl)
//   slave  - the CPU/bus/mux side that feeds and consumes those signals
// ---------------------------------------------------------------------------
interface oam_dma_ctrl_if;
  logic [15:0] i_bus_addr;
  logic        i_bus_wn;
  logic [7:0]  i_bus_wdata;
  logic [7:0]  i_bus_rdata;
  logic        o_dma_active;
  logic [15:0] o_dma_addr;
  logic        o_dma_wn;
  logic [7:0]  o_dma_wdata;
  logic        o_cpu_rdy;
  logic        o_done;

  modport master (
    input  i_bus_addr, i_bus_wn, i_bus_wdata, i_bus_rdata,
    output o_dma_active, o_dma_addr, o_dma_wn, o_dma_wdata, o_cpu_rdy, o_done
  );

  modport slave (
    output i_bus_addr, i_bus_wn, i_bus_wdata, i_bus_rdata,
    input  o_dma_active, o_dma_addr, o_dma_wn, o_dma_wdata, o_cpu_rdy, o_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// Sprite DMA initiator. A CPU write to DMA_REG_ADDR latches a source page,
// stalls the CPU and copies 256 bytes from {page,00..FF} to DST_ADDR as
// alternating read/write bus cycles, then pulses o_done.
//
// Ports:
//   i_cpu_clk    CPU clock
//   i_cpu_rstn   asynchronous active-low reset
//   bus          oam_dma_ctrl_if.master (snooped CPU bus + DMA bus drive)
//
// Parameters:
//   DMA_REG_ADDR  CPU write address that triggers a transfer (16'h4014)
//   DST_ADDR      address every byte is written to (16'h2004)
//
// Build option:
//   OAM_DMA_ALIGN_EN  when defined, a transfer that halts on an odd cycle
//                     inserts one ALIGN cycle (514-cycle stall instead of
//                     513). When undefined, ALIGN and the parity flop are
//                     not built and the stall is always 513 cycles.
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] DST_ADDR     = 16'h2004
) (
  input logic            i_cpu_clk,
  input logic            i_cpu_rstn,
  oam_dma_ctrl_if.master bus
);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;
`endif

  state_t     state_reg, state_next;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_data;
  logic       trigger;

  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_wn;
  logic [7:0]  dma_wdata;
  logic        cpu_rdy;
  logic        done;

  assign trigger = (bus.i_bus_addr == DMA_REG_ADDR) && !bus.i_bus_wn;

`ifdef OAM_DMA_ALIGN_EN
  // Free-running cycle parity; decides whether HALT needs an ALIGN cycle.
  logic r_odd;
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) r_odd <= 1'b0;
    else             r_odd <= ~r_odd;
  end
`endif

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      state_reg <= IDLE;
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
      r_data    <= 8'h00;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            r_page <= bus.i_bus_wdata;
            r_idx  <= 8'h00;
          end
        end
        READ:    r_data <= bus.i_bus_rdata;
        // r_idx stops at FF so it never carries into the page byte.
        WRITE:   if (r_idx != 8'hFF) r_idx <= r_idx + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    dma_active = 1'b0;
    dma_addr   = 16'h0000;
    dma_wn     = 1'b1;
    dma_wdata  = 8'h00;
    cpu_rdy    = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trigger) state_next = HALT;
      end
      HALT: begin
        cpu_rdy = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
        state_next = r_odd ? ALIGN : READ;
`else
        state_next = READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: begin
        cpu_rdy    = 1'b0;
        state_next = READ;
      end
`endif
      READ: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        dma_addr   = {r_page, r_idx};
        state_next = WRITE;
      end
      WRITE: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        dma_addr   = DST_ADDR;
        dma_wn     = 1'b0;
        dma_wdata  = r_data;
        state_next = (r_idx == 8'hFF) ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.o_dma_active = dma_active;
  assign bus.o_dma_addr   = dma_addr;
  assign bus.o_dma_wn     = dma_wn;
  assign bus.o_dma_wdata  = dma_wdata;
  assign bus.o_cpu_rdy    = cpu_rdy;
  assign bus.o_done       = done;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_ctrl
// Directed self-checking bench for oam_dma_ctrl. The memory model returns
// (low address byte ^ 8'hA5) for any DMA read, so write k must carry k^A5.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oam_dma_ctrl;
  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  oam_dma_ctrl_if ifc ();

  oam_dma_ctrl #(
    .DMA_REG_ADDR (16'h4014),
    .DST_ADDR     (16'h2004)
  ) dut (
    .i_cpu_clk  (clk),
    .i_cpu_rstn (rstn),
    .bus        (ifc)
  );

  assign ifc.i_bus_rdata = ifc.o_dma_addr[7:0] ^ 8'hA5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; mirrors the parity the DUT sees.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("ok   %-14s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU bus cycle: driven at a negedge, returns at the next negedge.
  task automatic cpu_cycle(input logic [15:0] a, input logic wn, input logic [7:0] d);
    ifc.i_bus_addr  = a;
    ifc.i_bus_wn    = wn;
    ifc.i_bus_wdata = d;
    @(negedge clk);
    ifc.i_bus_addr  = 16'h0000;
    ifc.i_bus_wn    = 1'b1;
    ifc.i_bus_wdata = 8'h00;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".rdy"}, {31'd0, ifc.o_cpu_rdy}, 32'd1);
    check({tag, ".act"}, {31'd0, ifc.o_dma_active}, 32'd0);
    check({tag, ".done"}, {31'd0, ifc.o_done}, 32'd0);
  endtask

  // Full transfer from page 'page'. want_odd selects the parity of the HALT
  // cycle; inject drives 8'h03 triggers mid-transfer; trig_in_done drives a
  // trigger during the DONE cycle (both must be ignored).
  task automatic run_transfer(input string tag, input logic [7:0] page,
                              input int want_odd, input bit inject, input bit trig_in_done);
    int stall, first_act, rd_n, wr_n, bad_rd, bad_wr, done_n, align;
    logic [15:0] last_rd;
    bit fin;
    stall = 0; first_act = -1; rd_n = 0; wr_n = 0; bad_rd = 0; bad_wr = 0;
    done_n = 0; last_rd = 16'h0; fin = 0;
    while (((cyc + 1) % 2) != want_odd) @(negedge clk);
    align = 0;
`ifdef OAM_DMA_ALIGN_EN
    align = want_odd;
`endif
    cpu_cycle(16'h4014, 1'b0, page);
    for (int c = 0; c < 700 && !fin; c++) begin
      if (!ifc.o_cpu_rdy) stall++;
      if (ifc.o_dma_active && first_act < 0) first_act = c;
      if (ifc.o_dma_active && ifc.o_dma_wn) begin
        if (ifc.o_dma_addr !== {page, rd_n[7:0]}) bad_rd++;
        last_rd = ifc.o_dma_addr;
        rd_n++;
      end
      if (ifc.o_dma_active && !ifc.o_dma_wn) begin
        if (ifc.o_dma_addr !== 16'h2004 || ifc.o_dma_wdata !== (wr_n[7:0] ^ 8'hA5)) bad_wr++;
        wr_n++;
      end
      if (ifc.o_done) begin
        done_n++;
        fin = 1;
      end
      if ((inject && (c == 5 || c == 300)) || (trig_in_done && ifc.o_done))
        cpu_cycle(16'h4014, 1'b0, 8'h03);
      else
        @(negedge clk);
    end
    check({tag, ".stall"}, stall, 513 + align);
    check({tag, ".first_rd"}, first_act, 1 + align);
    check({tag, ".reads"}, rd_n, 256);
    check({tag, ".writes"}, wr_n, 256);
    check({tag, ".bad_rd"}, bad_rd, 0);
    check({tag, ".bad_wr"}, bad_wr, 0);
    check({tag, ".last_rd"}, {16'd0, last_rd}, {16'd0, page, 8'hFF});
    check({tag, ".done_n"}, done_n, 1);
    for (int i = 0; i < 3; i++) begin
      check_idle({tag, ".post"});
      @(negedge clk);
    end
  endtask

  initial begin
    int wr_n, done_n;
    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0;
    ifc.i_bus_addr  = 16'h0000;
    ifc.i_bus_wn    = 1'b1;
    ifc.i_bus_wdata = 8'h00;
    #2;
    check("rst.active", {31'd0, ifc.o_dma_active}, 32'd0);
    check("rst.addr", {16'd0, ifc.o_dma_addr}, 32'd0);
    check("rst.wn", {31'd0, ifc.o_dma_wn}, 32'd1);
    check("rst.wdata", {24'd0, ifc.o_dma_wdata}, 32'd0);
    check("rst.rdy", {31'd0, ifc.o_cpu_rdy}, 32'd1);
    check("rst.done", {31'd0, ifc.o_done}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Non-trigger accesses: write to $4015, read of $4014.
    cpu_cycle(16'h4015, 1'b0, 8'h02);
    check_idle("t6.w4015");
    cpu_cycle(16'h4014, 1'b1, 8'h02);
    check_idle("t6.r4014");
    @(negedge clk);
    check_idle("t6.later");

    run_transfer("t1.even", 8'h02, 0, 1'b0, 1'b0);
    run_transfer("t2.odd", 8'h02, 1, 1'b0, 1'b0);
    run_transfer("t3.pg07", 8'h07, 0, 1'b0, 1'b0);
    run_transfer("t4.inject", 8'h02, 1, 1'b1, 1'b1);
    run_transfer("t4.fresh", 8'h03, 0, 1'b0, 1'b0);
    run_transfer("t3.pg20", 8'h20, 1, 1'b0, 1'b0);

    // Reset in the middle of a transfer, after 100 writes.
    cpu_cycle(16'h4014, 1'b0, 8'h09);
    wr_n = 0;
    done_n = 0;
    for (int c = 0; c < 400 && wr_n < 100; c++) begin
      if (ifc.o_dma_active && !ifc.o_dma_wn) wr_n++;
      if (ifc.o_done) done_n++;
      if (wr_n < 100) @(negedge clk);
    end
    check("t5.writes", wr_n, 100);
    check("t5.midbusy", {31'd0, ifc.o_cpu_rdy}, 32'd0);
    #1 rstn = 1'b0;
    #1;
    check("t5.active", {31'd0, ifc.o_dma_active}, 32'd0);
    check("t5.addr", {16'd0, ifc.o_dma_addr}, 32'd0);
    check("t5.wn", {31'd0, ifc.o_dma_wn}, 32'd1);
    check("t5.wdata", {24'd0, ifc.o_dma_wdata}, 32'd0);
    check("t5.rdy", {31'd0, ifc.o_cpu_rdy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ifc.o_done) done_n++;
    end
    check("t5.no_done", done_n, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_idle("t5.released");
    run_transfer("t5.after", 8'h0A, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute safety net; the directed sequence finishes far earlier.
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
